// File: rtl/vendingmachine_param.sv
// Parameterised vending machine: multi-product stock, coin credit,
// optional auto-vend, registered outputs and serial change return.
module vendingmachine_param #(
  parameter int PRICE      = 3,
  parameter int CW         = 4,
  parameter int NPROD      = 2,
  parameter int SELW       = 1,
  parameter int SW         = 4,
  parameter int STOCK_INIT = 8,
  parameter int AUTO_VEND  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             one_in,
  input  logic             two_in,
  input  logic             buy_in,
  input  logic [SELW-1:0]  sel_in,
  input  logic             cancel_in,
  input  logic             restock_in,
  output logic [NPROD-1:0] choco_out,
  output logic             chng_out,
  output logic [CW-1:0]    credit_out,
  output logic [NPROD-1:0] sold_out,
  output logic             busy_out,
  output logic             err_out,
  output logic             reject_out
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [CW+1:0] CMAX = {2'b00, {CW{1'b1}}};

  state_t           state, state_n;
  logic [SW-1:0]    stock   [NPROD];
  logic [SW-1:0]    stock_n [NPROD];
  logic [CW-1:0]    credit_n;
  logic [NPROD-1:0] choco_n, sold_n;
  logic             chng_n, err_n, rej_n;
  logic [1:0]       coins;
  logic [CW+1:0]    sum;
  logic [SELW-1:0]  idx;
  logic [SW-1:0]    cur;
  logic             ok_sel, can_pay, req, accept;

  always_comb begin
    coins    = {two_in, one_in};
    sum      = {2'b00, credit_out} + {{CW{1'b0}}, coins};
    idx      = (AUTO_VEND != 0) ? '0 : sel_in;
    ok_sel   = int'(idx) < NPROD;
    cur      = '0;
    for (int i = 0; i < NPROD; i++)
      if (int'(idx) == i) cur = stock[i];
    can_pay  = credit_out >= CW'(PRICE);
    accept   = can_pay && ok_sel && (cur != '0);
    req      = (AUTO_VEND != 0) ? accept : buy_in;

    state_n  = state;
    credit_n = credit_out;
    stock_n  = stock;
    choco_n  = '0;
    chng_n   = 1'b0;
    err_n    = 1'b0;
    rej_n    = one_in | two_in;

    unique case (state)
      IDLE: begin
        if (cancel_in) begin
          if (credit_out != '0) state_n = CHANGE;
        end else if (restock_in) begin
          for (int i = 0; i < NPROD; i++)
            stock_n[i] = SW'(STOCK_INIT);
        end else if (req) begin
          if (accept) begin
            credit_n = credit_out - CW'(PRICE);
            for (int i = 0; i < NPROD; i++)
              if (int'(idx) == i) begin
                stock_n[i] = stock[i] - 1'b1;
                choco_n[i] = 1'b1;
              end
            state_n = VEND;
          end else begin
            err_n = 1'b1;
          end
        end else if (coins != 2'b00 && sum <= CMAX) begin
          credit_n = sum[CW-1:0];
          rej_n    = 1'b0;
        end
      end
      VEND: state_n = (credit_out != '0) ? CHANGE : IDLE;
      CHANGE: begin
        if (credit_out != '0) begin
          credit_n = credit_out - 1'b1;
          chng_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    for (int i = 0; i < NPROD; i++)
      sold_n[i] = (stock_n[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      credit_out <= '0;
      for (int i = 0; i < NPROD; i++)
        stock[i] <= SW'(STOCK_INIT);
      choco_out  <= '0;
      chng_out   <= 1'b0;
      sold_out   <= (STOCK_INIT == 0) ? '1 : '0;
      busy_out   <= 1'b0;
      err_out    <= 1'b0;
      reject_out <= 1'b0;
    end else begin
      state      <= state_n;
      credit_out <= credit_n;
      stock      <= stock_n;
      choco_out  <= choco_n;
      chng_out   <= chng_n;
      sold_out   <= sold_n;
      busy_out   <= (state_n != IDLE);
      err_out    <= err_n;
      reject_out <= rej_n;
    end
  end

endmodule

// File: doc/vendingmachine_param.md
VENDINGMACHINE_PARAM -- requirements
Module: vendingmachine_param

Parameters
REQ-001 PRICE, default 3: product price in coin units; valid range 1..2^CW-1.
REQ-002 CW, default 4: credit register width; CMAX = 2^CW-1.
REQ-003 NPROD, default 2: product count; valid range 1..2^SELW.
REQ-004 SELW, default 1: width of sel_in.
REQ-005 SW, default 4: per-product stock counter width.
REQ-006 STOCK_INIT, default 8: stock loaded at reset and restock; valid range 0..2^SW-1.
REQ-007 AUTO_VEND, default 0: 1 = vend product 0 automatically once credit >= PRICE; 0 = vend only on buy_in.

Interface
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 one_in  in  1  one-unit coin; each sampled-high cycle is one coin.
REQ-011 two_in  in  1  two-unit coin; each sampled-high cycle is one coin.
REQ-012 buy_in  in  1  purchase request for product sel_in; ignored when AUTO_VEND=1.
REQ-013 sel_in  in  SELW  product index.
REQ-014 cancel_in  in  1  refund all credit.
REQ-015 restock_in  in  1  reload all stock counters.
REQ-016 choco_out  out  NPROD  one-hot dispense pulse.
REQ-017 chng_out  out  1  one pulse per returned unit.
REQ-018 credit_out  out  CW  current credit.
REQ-019 sold_out  out  NPROD  bit i high while stock[i]=0.
REQ-020 busy_out  out  1  high in VEND and CHANGE.
REQ-021 err_out  out  1  one-cycle pulse: buy refused.
REQ-022 reject_out  out  1  one-cycle pulse: coin refused and not credited.

Function
REQ-023 All outputs registered; states IDLE, VEND, CHANGE.
REQ-024 IDLE, per-cycle priority: cancel_in > restock_in > buy/auto-vend > coins.
REQ-025 IDLE coins: add one_in*1 + two_in*2 (both high = 3) in that cycle; if the sum exceeds CMAX, discard the whole sum, leave credit unchanged, and pulse reject_out.
REQ-026 Coins high in any cycle where a higher-priority IDLE action is taken, or in VEND/CHANGE, are discarded with a reject_out pulse.
REQ-027 IDLE cancel_in with credit>0: go to CHANGE; with credit=0: no effect.
REQ-028 IDLE restock_in: all stock counters set to STOCK_INIT; credit unchanged.
REQ-029 IDLE buy accepted when credit >= PRICE, sel_in < NPROD and stock[sel_in] > 0: at that edge credit -= PRICE, stock[sel_in] -= 1, and the FSM goes to VEND.
REQ-030 Buy refused otherwise: err_out pulses the next cycle; credit and stock unchanged.
REQ-031 AUTO_VEND=1: condition credit >= PRICE with stock[0] > 0 acts as an accepted buy of product 0; with stock[0]=0, no vend and no err_out, and credit is held.
REQ-032 VEND lasts exactly one cycle, with choco_out[sel] = 1; then go to CHANGE if credit > 0, else IDLE.
REQ-033 CHANGE: chng_out = 1 for exactly `credit` consecutive cycles; credit decrements by 1 per cycle; return to IDLE in the cycle after credit reaches 0.
REQ-034 All inputs except reset are ignored in VEND and CHANGE, apart from coin rejection.
REQ-035 Stock never wraps below 0; credit never exceeds CMAX.

Reset
REQ-036 reset=0 at an edge: state IDLE; credit 0; every stock counter = STOCK_INIT; choco_out, chng_out, err_out, reject_out and busy_out = 0; sold_out reflects STOCK_INIT.
REQ-037 Reset mid-VEND or mid-CHANGE aborts immediately: remaining change is not paid and credit is 0.

Verification (PRICE=3, CW=4, NPROD=2, STOCK_INIT=2, AUTO_VEND=0 unless noted)
REQ-038 Hold reset low 2 cycles, then one_in high 3 cycles -> credit_out steps 1, 2, 3; no other output activity.
REQ-039 two_in high 2 cycles (credit 4), then buy_in with sel_in=1 -> one cycle choco_out=2'b10, then one chng_out cycle, then credit 0 and busy_out low.
REQ-040 Credit 2, then buy_in -> err_out pulses once; credit stays 2. Two exact-credit buys of product 0 -> sold_out=2'b01; third buy -> err_out; restock_in -> sold_out=0.
REQ-041 Credit 5, then cancel_in -> 5 consecutive chng_out cycles with busy_out high; two_in during CHANGE -> reject_out, credit unaffected.
REQ-042 Credit 14, then two_in -> reject_out, credit stays 14. With AUTO_VEND=1, one_in then two_in -> choco_out=2'b01 with no buy_in.
REQ-043 reset low on the 2nd cycle of CHANGE from credit 4 -> next cycle credit 0, chng_out 0, and state IDLE.
